// File: rtl/sbox_sub_engine.sv
// Table-programmable DES-style S-box substitution engine: NUM_BOX parallel 6->OUT_W lookups,
// two-stage valid/ready pipeline, table writes accepted only while the pipeline is drained.
module sbox_sub_engine #(
  parameter int NUM_BOX = 8,
  parameter int IN_W    = 6,
  parameter int OUT_W   = 4,
  localparam int BOX_W  = (NUM_BOX > 1) ? $clog2(NUM_BOX) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_BOX*IN_W-1:0]  in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_BOX*OUT_W-1:0] out_data,
  input  logic                     cfg_we,
  output logic                     cfg_ready,
  input  logic [BOX_W-1:0]         cfg_box,
  input  logic [1:0]               cfg_row,
  input  logic [3:0]               cfg_col,
  input  logic [OUT_W-1:0]         cfg_data
);

  logic [OUT_W-1:0]         tbl_r [NUM_BOX][64];
  logic                     s1_valid_r;
  logic [NUM_BOX*IN_W-1:0]  s1_data_r;
  logic                     out_valid_r;
  logic [NUM_BOX*OUT_W-1:0] out_data_r;
  logic [NUM_BOX*OUT_W-1:0] lut_s;
  logic                     s2_load_s;
  logic                     in_fire_s;
  logic                     cfg_fire_s;
  logic                     cfg_box_ok_s;

  // Row is the outer bit pair, column the middle four bits.
  function automatic logic [5:0] lut_idx(input logic [5:0] x);
    return {x[5], x[0], x[4:1]};
  endfunction

  // Handshake and advance decisions.
  always_comb begin
    s2_load_s    = !out_valid_r || out_ready;
    in_ready     = !rst && !cfg_we && (!s1_valid_r || s2_load_s);
    cfg_ready    = !rst && !s1_valid_r && !out_valid_r;
    in_fire_s    = in_valid && in_ready;
    cfg_fire_s   = cfg_we && cfg_ready;
    cfg_box_ok_s = int'(cfg_box) < NUM_BOX;
  end

  // Parallel lookup of every box from the S1 word.
  always_comb begin
    lut_s = {(NUM_BOX*OUT_W){1'b0}};
    for (int k = 0; k < NUM_BOX; k++) begin
      lut_s[OUT_W*k +: OUT_W] = tbl_r[k][lut_idx(s1_data_r[IN_W*k +: 6])];
    end
  end

  // Substitution tables; out-of-range box writes complete the handshake but are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_BOX; k++) begin
        for (int e = 0; e < 64; e++) begin
          tbl_r[k][e] <= {OUT_W{1'b0}};
        end
      end
    end else if (cfg_fire_s && cfg_box_ok_s) begin
      tbl_r[cfg_box][{cfg_row, cfg_col}] <= cfg_data;
    end
  end

  // Stage S1: input capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= {(NUM_BOX*IN_W){1'b0}};
    end else if (!s1_valid_r || s2_load_s) begin
      s1_valid_r <= in_fire_s;
      if (in_fire_s) begin
        s1_data_r <= in_data;
      end
    end
  end

  // Stage S2: result register; data only changes when a new word arrives, so it holds under stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {(NUM_BOX*OUT_W){1'b0}};
    end else if (s2_load_s) begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        out_data_r <= lut_s;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

endmodule

// File: tb/tb_sbox_sub_engine.sv
// Self-checking bench for sbox_sub_engine: directed vector table, hand-written stall/config/reset
// sequences and randomized traffic scored against a table-and-queue reference model.
module tb_sbox_sub_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        cfg_we;
  logic        cfg_ready;
  logic [2:0]  cfg_box;
  logic [1:0]  cfg_row;
  logic [3:0]  cfg_col;
  logic [3:0]  cfg_data;

  int vectors = 0;
  int miscompares = 0;
  int rx_count = 0;

  logic [3:0]  mtab [8][64];
  logic [31:0] q [$];

  typedef struct {
    logic [47:0] din;
    logic [31:0] exp;
  } vec_t;
  vec_t vt [6];

  sbox_sub_engine dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_ready(cfg_ready), .cfg_box(cfg_box),
    .cfg_row(cfg_row), .cfg_col(cfg_col), .cfg_data(cfg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: row from the outer bits, column from the middle bits, plain arithmetic.
  function automatic logic [31:0] m_lookup(input logic [47:0] d);
    logic [31:0] r;
    r = 32'h0;
    for (int k = 0; k < 8; k++) begin
      int xi, row, col;
      xi  = int'(d[6*k +: 6]);
      row = (xi / 32) * 2 + (xi % 2);
      col = (xi / 2) % 16;
      r[4*k +: 4] = mtab[k][row*16 + col];
    end
    return r;
  endfunction

  // Scoreboard: observes every handshake mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      for (int k = 0; k < 8; k++)
        for (int e = 0; e < 64; e++)
          mtab[k][e] = 4'h0;
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", {47'h0, out_valid}, 48'h0);
        end else begin
          chk("sb_out_data", {16'h0, out_data}, {16'h0, q[0]});
          if (out_ready) begin
            void'(q.pop_front());
            rx_count++;
          end
        end
      end
      if (in_valid && in_ready) q.push_back(m_lookup(in_data));
      if (cfg_we && cfg_ready) mtab[cfg_box][int'(cfg_row)*16 + int'(cfg_col)] = cfg_data;
    end
  end

  task automatic send_one(input logic [47:0] din, input logic [31:0] exp, input string nm);
    in_valid = 1'b1;
    in_data  = din;
    @(negedge clk); chk({nm, "_in_ready"}, {47'h0, in_ready}, 48'h1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk); chk({nm, "_early_valid"}, {47'h0, out_valid}, 48'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({nm, "_valid"}, {47'h0, out_valid}, 48'h1);
    chk({nm, "_data"}, {16'h0, out_data}, {16'h0, exp});
    @(posedge clk); #1;
  endtask

  task automatic cfg_write(input logic [2:0] b, input logic [1:0] r, input logic [3:0] c,
                           input logic [3:0] d);
    int n;
    n = 0;
    cfg_we = 1'b1; cfg_box = b; cfg_row = r; cfg_col = c; cfg_data = d;
    @(negedge clk);
    while (!cfg_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("cfg_ready_wait", {47'h0, cfg_ready}, 48'h1);
    @(posedge clk); #1 cfg_we = 1'b0;
  endtask

  initial begin
    int n;
    int rx0;
    rst = 1'b1; in_valid = 1'b0; in_data = 48'h0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_box = 3'd0; cfg_row = 2'd0; cfg_col = 4'd0; cfg_data = 4'd0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {47'h0, in_ready}, 48'h0);
    chk("rst_cfg_ready", {47'h0, cfg_ready}, 48'h0);
    chk("rst_out_valid", {47'h0, out_valid}, 48'h0);
    chk("rst_out_data", {16'h0, out_data}, 48'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", {47'h0, in_ready}, 48'h1);
    chk("idle_cfg_ready", {47'h0, cfg_ready}, 48'h1);
    @(posedge clk); #1;

    send_one(48'h0, 32'h0, "zero");

    cfg_write(3'd7, 2'd1, 4'd15, 4'd5);
    send_one(48'h1F << 42, 32'h5000_0000, "box7");

    // DES S2 entries on box 0, back-to-back lookups
    cfg_write(3'd0, 2'd0, 4'd0, 4'd15);
    cfg_write(3'd0, 2'd3, 4'd0, 4'd13);
    in_valid = 1'b1; in_data = 48'h0;
    @(negedge clk); chk("b2b_rdy0", {47'h0, in_ready}, 48'h1);
    @(posedge clk); #1 in_data = 48'h21;
    @(negedge clk); chk("b2b_rdy1", {47'h0, in_ready}, 48'h1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_v0", {47'h0, out_valid}, 48'h1);
    chk("b2b_d0", {44'h0, out_data[3:0]}, 48'hF);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b_v1", {47'h0, out_valid}, 48'h1);
    chk("b2b_d1", {44'h0, out_data[3:0]}, 48'hD);
    @(posedge clk); #1;
    @(negedge clk); chk("b2b_done", {47'h0, out_valid}, 48'h0);
    @(posedge clk); #1;

    // Directed vector table
    cfg_write(3'd3, 2'd2, 4'd9, 4'hA);
    cfg_write(3'd5, 2'd1, 4'd3, 4'h7);
    vt[0] = '{din: 48'h0,             exp: 32'h0000_000F};
    vt[1] = '{din: 48'h21,            exp: 32'h0000_000D};
    vt[2] = '{din: 48'hC8_0000,       exp: 32'h0000_A00F};
    vt[3] = '{din: 48'h0001_C000_0021, exp: 32'h0070_000D};
    vt[4] = '{din: 48'h7C00_00C8_0021, exp: 32'h5000_A00D};
    vt[5] = '{din: 48'hFFFF_FFFF_FFFF, exp: 32'h0000_0000};
    for (int i = 0; i < 6; i++) send_one(vt[i].din, vt[i].exp, $sformatf("vec%0d", i));

    // Backpressure: two words fit, third waits; results in order after release
    out_ready = 1'b0; rx0 = rx_count;
    in_valid = 1'b1; in_data = 48'h21;
    @(negedge clk); chk("bp_rdy0", {47'h0, in_ready}, 48'h1);
    @(posedge clk); #1 in_data = 48'h0;
    @(negedge clk); chk("bp_rdy1", {47'h0, in_ready}, 48'h1);
    @(posedge clk); #1 in_data = 48'h7C00_00C8_0021;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_rdy2_low", {47'h0, in_ready}, 48'h0);
      chk("bp_hold_data", {16'h0, out_data}, 48'hD);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("bp_rx_count", 48'(rx_count - rx0), 48'd3);
    chk("bp_queue_empty", 48'(q.size()), 48'd0);

    // Config request while busy: in-flight word keeps the old entry
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 48'h0;
    @(negedge clk); chk("busy_rdy", {47'h0, in_ready}, 48'h1);
    @(posedge clk); #1 in_valid = 1'b0;
    cfg_we = 1'b1; cfg_box = 3'd0; cfg_row = 2'd0; cfg_col = 4'd0; cfg_data = 4'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("busy_cfg_ready", {47'h0, cfg_ready}, 48'h0);
      chk("busy_in_ready", {47'h0, in_ready}, 48'h0);
    end
    chk("busy_old_valid", {47'h0, out_valid}, 48'h1);
    chk("busy_old_data", {16'h0, out_data}, 48'hF);
    @(posedge clk); #1 out_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!cfg_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("busy_cfg_drained", {47'h0, cfg_ready}, 48'h1);
    @(posedge clk); #1 cfg_we = 1'b0;
    send_one(48'h0, 32'h3, "newtab");

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = {16'($urandom), 32'($urandom)};
      out_ready = ($urandom_range(0, 3) != 0);
      cfg_we    = ($urandom_range(0, 9) == 0);
      cfg_box   = 3'($urandom);
      cfg_row   = 2'($urandom);
      cfg_col   = 4'($urandom);
      cfg_data  = 4'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rand_drained", 48'(q.size()), 48'd0);

    // Reset with two words in flight
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 48'h21;
    @(posedge clk); #1 in_data = 48'h0;
    @(posedge clk); #1 in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", {47'h0, in_ready}, 48'h0);
    chk("mid_rst_cfg_ready", {47'h0, cfg_ready}, 48'h0);
    @(posedge clk); #1 rst = 1'b0;
    chk("mid_rst_out_valid", {47'h0, out_valid}, 48'h0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {47'h0, in_ready}, 48'h1);
    chk("post_rst_cfg_ready", {47'h0, cfg_ready}, 48'h1);
    @(posedge clk); #1;
    send_one(48'h0, 32'h0, "cleared_box0");
    send_one(48'h1F << 42, 32'h0, "cleared_box7");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sbox_sub_engine.md
# sbox_sub_engine

Parametrised, table-programmable S-box substitution engine for the encryption path. It applies NUM_BOX independent 6-to-4-bit substitutions in parallel to one input word per cycle and returns the result two cycles later. All tables are runtime-loadable, so one instance can serve any DES-style S-box set. It sits between the expansion/key-mix stage and the permutation stage, with valid/ready handshakes on both sides and a separate configuration write port.

## Interface
- NUM_BOX, 8, number of parallel S-boxes
- IN_W, 6, bits per box input (fixed row/column split below; only 6 supported)
- OUT_W, 4, bits per box output
- clk  in  1  single clock; everything on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input word valid
- in_ready  out  1  engine can accept input this cycle
- in_data  in  NUM_BOX*IN_W  box k uses in_data[IN_W*k+5 : IN_W*k]
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  NUM_BOX*OUT_W  box k result on out_data[OUT_W*k+3 : OUT_W*k]
- cfg_we  in  1  table write request
- cfg_ready  out  1  table write accepted when cfg_we & cfg_ready
- cfg_box  in  clog2(NUM_BOX)  target box
- cfg_row  in  2  target row
- cfg_col  in  4  target column
- cfg_data  in  OUT_W  entry value

## Operation
- Per-box table: 64 entries x OUT_W, flop-based. Index = {row, col}; for a 6-bit box input x: row = {x[5], x[0]}, col = x[4:1].
- Reset clears every table entry to 0.
- cfg_box >= NUM_BOX: write accepted (handshake completes) but discarded.
- Pipeline: stage S1 registers in_data plus valid; stage S2 performs lookup for all boxes and registers out_data plus out_valid.
- Advance rule: S2 loads when !out_valid | out_ready. S1 loads when S1 empty or S1 moving into S2.
- in_ready = !rst & !cfg_we & (S1 empty | S2 will load this cycle).
- cfg_ready = !rst & S1 empty & S2 empty (pipeline fully drained). Prevents table change under in-flight data; results always reflect tables at acceptance.
- Simultaneous cfg_we and in_valid on an empty pipeline: config write wins, in_ready = 0 that cycle; input retried next cycle.
- out_data holds its value while out_valid & !out_ready. out_data keeps last value after out_valid drops.

## Timing
- Reset values: out_valid = 0, out_data = 0, S1 valid = 0, all table entries = 0; in_ready = 0 and cfg_ready = 0 while rst is high, both 1 the cycle after rst deasserts (idle).
- Latency: input accepted at edge t -> out_valid high after edge t+2 when no stall.
- Throughput: one word per cycle with out_ready held high.
- Stall: with out_ready low, at most 2 words in flight; third in_valid sees in_ready = 0.
- Config write visible to a lookup in the first input accepted on a later cycle.
- rst mid-operation: in-flight data dropped, out_valid = 0 next cycle, tables cleared; no partial result emitted.

## Test plan
- Reset then in_data = all zeros, out_ready = 1 -> out_valid at t+2 with out_data = 0.
- Program box 0 with DES S2 row 0 col 0 = 15 and row 3 col 0 = 13; send box 0 inputs 6'b000000 then 6'b100001 back-to-back -> out_data[3:0] = 15 then 13 on consecutive cycles, latency 2.
- Program box 7 row 1 col 15 = 5 (NUM_BOX = 8); input box 7 = 6'b011111, others 0 -> out_data[31:28] = 5, out_data[27:0] = 0.
- Backpressure: out_ready low, offer 3 words -> two accepted, in_ready low for the third; out_data stable while stalled; release -> three results in order, no loss or duplication.
- Config during busy: word in flight, cfg_we high -> cfg_ready = 0 until drained; write then lands and in-flight result uses old table value.
- Assert rst while 2 words in flight -> out_valid = 0 the next cycle; earlier-programmed entry reads back 0 afterwards.
